// File: rtl/aes_key_sched_ctrl.sv
// ============================================================================
// Module:      aes_key_sched_ctrl
// Description: AES-128 key-schedule sequencer: loads the cipher key into the
//              expander, then streams 44 round-key words to the datapath.
//              Optional expansion timeout: define AES_KEY_SCHED_TIMEOUT_EN.
// Revision:    1.0 - initial release
// ============================================================================
`default_nettype none

module aes_key_sched_ctrl #(
    parameter int NR          = 10,
    parameter int EXP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] key_word,
    input  logic        key_valid,
    output logic        key_ready,
    output logic        ke_start,
    output logic [31:0] ke_key,
    input  logic        ke_done,
    output logic [3:0]  ke_round_n,
    output logic [1:0]  ke_r_index,
    input  logic [31:0] ke_round_key,
    output logic [31:0] rk_word,
    output logic [3:0]  rk_round,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic        rk_last,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_EXPAND = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    logic [2:0] state;
    logic [1:0] word_cnt;
    logic [3:0] round_cnt;
    logic       issuing;
    logic       last_word;

`ifdef AES_KEY_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(EXP_TIMEOUT + 1);
    logic [TW-1:0] timer;
`else
    logic unused_cfg;
    assign unused_cfg = (EXP_TIMEOUT != 0);
    assign err        = 1'b0;
`endif

    assign issuing   = (state == S_ISSUE);
    assign last_word = (round_cnt == LAST_ROUND) && (word_cnt == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            word_cnt  <= 2'd0;
            round_cnt <= 4'd0;
`ifdef AES_KEY_SCHED_TIMEOUT_EN
            timer     <= '0;
            err       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        word_cnt <= 2'd0;
                    end
                end
                S_LOAD: begin
                    if (key_valid) begin
                        word_cnt <= word_cnt + 2'd1;
                        if (word_cnt == 2'd3) begin
                            state    <= S_EXPAND;
                            word_cnt <= 2'd0;
`ifdef AES_KEY_SCHED_TIMEOUT_EN
                            timer    <= '0;
`endif
                        end
                    end
                end
                S_EXPAND: begin
                    // ke_done has priority over a simultaneous timeout expiry
                    if (ke_done) begin
                        state     <= S_ISSUE;
                        round_cnt <= 4'd0;
                        word_cnt  <= 2'd0;
                    end
`ifdef AES_KEY_SCHED_TIMEOUT_EN
                    else if (timer == TW'(EXP_TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
                S_ISSUE: begin
                    if (rk_ready) begin
                        word_cnt <= word_cnt + 2'd1;
                        if (last_word) begin
                            state <= S_DONE;
                        end else if (word_cnt == 2'd3) begin
                            round_cnt <= round_cnt + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from state so reset clears them without a clock edge
    assign key_ready  = (state == S_LOAD);
    assign ke_start   = key_valid & key_ready;
    assign ke_key     = key_word;
    assign rk_valid   = issuing;
    assign ke_round_n = issuing ? round_cnt : 4'd0;
    assign ke_r_index = issuing ? (2'd3 - word_cnt) : 2'd0;
    assign rk_round   = issuing ? round_cnt : 4'd0;
    assign rk_word    = ke_round_key;
    assign rk_last    = issuing & last_word;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
// ============================================================================
// Module:      tb_aes_key_sched_ctrl
// Description: Self-checking bench for aes_key_sched_ctrl with a FIPS-197
//              key-expander model. Honours AES_KEY_SCHED_TIMEOUT_EN.
// Revision:    1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] key_word;
    logic        key_valid;
    logic        key_ready;
    logic        ke_start;
    logic [31:0] ke_key;
    logic        ke_done;
    logic [3:0]  ke_round_n;
    logic [1:0]  ke_r_index;
    logic [31:0] ke_round_key;
    logic [31:0] rk_word;
    logic [3:0]  rk_round;
    logic        rk_valid;
    logic        rk_ready;
    logic        rk_last;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic [1407:0] ke_model;   // words captured by the expander model
    logic [1407:0] exp_model;  // words the scoreboard expects

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.NR(10), .EXP_TIMEOUT(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .key_word     (key_word),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .ke_start     (ke_start),
        .ke_key       (ke_key),
        .ke_done      (ke_done),
        .ke_round_n   (ke_round_n),
        .ke_r_index   (ke_r_index),
        .ke_round_key (ke_round_key),
        .rk_word      (rk_word),
        .rk_round     (rk_round),
        .rk_valid     (rk_valid),
        .rk_ready     (rk_ready),
        .rk_last      (rk_last),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    // ---------------- FIPS-197 reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [1407:0] w = '0;
        logic [31:0]   t;
        logic [7:0]    rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i*32 +: 32] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[(i-1)*32 +: 32];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i*32 +: 32] = w[(i-4)*32 +: 32] ^ t;
        end
        return w;
    endfunction

    // Expander model: slice 0 is the least significant word of the round key
    always_comb begin
        int idx;
        idx = int'(ke_round_n) * 4 + 3 - int'(ke_r_index);
        ke_round_key = (idx < 44) ? ke_model[idx*32 +: 32] : 32'hdead_beef;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] r10;
        bit           has_r10;
        bit           gapped;
        bit           bp;
        bit           poke;
    } vec_t;

    // One full transaction. abort_at>=0 resets mid-ISSUE at that word index;
    // no_done holds ke_done low to exercise the expansion timeout path.
    task automatic run_key(input vec_t v, input int abort_at, input bit no_done);
        bit   pat[6] = '{1, 0, 1, 1, 0, 1};
        int   idx = 0;
        int   p = 0;
        int   n_start = 0;
        int   cyc;
        int   i;
        bit   hold = 0;
        logic [41:0] held;
        logic [127:0] cap = '0;

        exp_model = expand(v.key);
        if (v.has_r10)
            for (int j = 0; j < 4; j++) exp_model[(40+j)*32 +: 32] = v.r10[127 - 32*j -: 32];

        @(negedge clk);
        start = 1; key_valid = 0; ke_done = 0; rk_ready = 0;
        #1 chk("idle_key_ready", key_ready, 0);
        @(negedge clk);
        start = 0;
        #1 chk("start_to_key_ready", key_ready, 1);

        cyc = 0;
        while (idx < 4 && cyc < 50) begin
            key_valid = v.gapped ? pat[p % 6] : 1'b1;
            key_word  = key_valid ? v.key[127 - 32*idx -: 32] : $urandom;
            p++;
            #1;
            chk("ke_start_eq_valid", ke_start, key_valid);
            if (ke_start) begin
                chk("ke_key", ke_key, v.key[127 - 32*idx -: 32]);
                cap[127 - 32*idx -: 32] = ke_key;
                n_start++;
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        chk("ke_start_count", n_start, 4);
        key_valid = 1; key_word = $urandom;
        #1 chk("expand_entered", {busy, key_ready, ke_start, rk_valid}, 4'b1000);
        key_valid = 0;
        ke_model = expand(cap);

        if (no_done) begin
            cyc = 1;
            while (busy && cyc < 1000) begin
                if (rk_valid) chk("timeout_no_rk_valid", rk_valid, 0);
                @(negedge clk);
                #1;
                if (busy) cyc++;
            end
`ifdef AES_KEY_SCHED_TIMEOUT_EN
            chk("timeout_cycles", cyc, 64);
            chk("timeout_err_idle", {err, busy, rk_valid}, 3'b100);
`else
            chk("no_timeout_still_busy", {err, busy, rk_valid}, 3'b010);
            reset = 1;
            #1 chk("reset_clears_busy", busy, 0);
            @(negedge clk);
            reset = 0;
`endif
            return;
        end

        for (int d = 0; d < 3; d++) begin
            @(negedge clk);
            start = v.poke && (d == 1);
            #1 chk("expand_wait", {busy, rk_valid}, 2'b10);
        end
        @(negedge clk);
        start = 0; ke_done = 1;
        #1 chk("done_seen_no_valid_yet", rk_valid, 0);
        @(negedge clk);
        #1 chk("ke_done_to_rk_valid", rk_valid, 1);

        i = 0; cyc = 0;
        while (i < 44 && cyc < 1000) begin
            if (i == abort_at) begin
                reset = 1;
                #1 chk("async_reset_outputs",
                       {key_ready, ke_start, rk_valid, rk_last, busy, done, err,
                        ke_round_n, ke_r_index, rk_round}, '0);
                @(negedge clk);
                reset = 0; ke_done = 0;
                @(negedge clk);
                #1 chk("idle_after_reset", {busy, rk_valid, key_ready}, 3'b000);
                return;
            end
            rk_ready = v.bp ? 1'($urandom % 2) : 1'b1;
            start    = v.poke && (cyc == 5);
            #1;
            chk("rk_valid_held", rk_valid, 1);
            if (hold)
                chk("stable_under_backpressure",
                    {rk_word, rk_round, ke_round_n, ke_r_index}, held);
            if (rk_ready) begin
                chk($sformatf("rk_word[%0d]", i), rk_word, exp_model[i*32 +: 32]);
                chk($sformatf("rk_round[%0d]", i), rk_round, i / 4);
                chk($sformatf("rk_last[%0d]", i), rk_last, (i == 43));
                i++;
                hold = 0;
            end else begin
                held = {rk_word, rk_round, ke_round_n, ke_r_index};
                hold = 1;
            end
            cyc++;
            @(negedge clk);
        end
        chk("all_words_issued", i, 44);
        if (!v.bp) chk("issue_cycles", cyc, 44);
        rk_ready = 0; start = 0;
        #1 chk("done_pulse", {done, rk_valid, busy}, 3'b101);
        @(negedge clk);
        ke_done = 0;
        #1 chk("done_one_cycle", {done, busy}, 2'b00);
    endtask

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        reset = 1; start = 0; key_word = 0; key_valid = 0;
        ke_done = 0; rk_ready = 0; ke_model = '0; exp_model = '0;

        vecs[0] = '{128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                    128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, 1, 1, 0, 1};
        vecs[1] = '{128'h0, 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e, 1, 0, 1, 0};
        for (int k = 2; k < 5; k++)
            vecs[k] = '{{$urandom, $urandom, $urandom, $urandom}, 128'h0, 0,
                        1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2)};

        #1 chk("reset_outputs",
               {key_ready, ke_start, rk_valid, rk_last, busy, done, err,
                ke_round_n, ke_r_index, rk_round}, '0);
        @(negedge clk);
        reset = 0;

        // key_valid without start in IDLE is ignored
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            key_valid = 1; key_word = $urandom;
            #1 chk("idle_ignores_key_valid", {key_ready, ke_start, busy}, 3'b000);
        end
        key_valid = 0;

        for (int k = 0; k < 5; k++) run_key(vecs[k], -1, 0);

        // Asynchronous reset in round 5, then a clean run afterwards
        run_key(vecs[0], 20, 0);
        v = vecs[0]; v.bp = 1;
        run_key(v, -1, 0);

        run_key(vecs[2], -1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Controller that sequences the AES-128 key-expansion block.
- Accepts a 128-bit cipher key as four 32-bit words over a valid/ready handshake and drives the expander's start/load interface.
- Waits for expansion to complete, then streams all 44 round-key words (rounds 0..NR, word 0..3 each) to the round datapath over a second valid/ready handshake.
- Sits between the top-level host interface, the key expander and the cipher round datapath.

Parameters:
- NR, 10, last round index; round keys 0..NR are issued.
- EXP_TIMEOUT, 64, cycles allowed in EXPAND before error (used only with the optional feature).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a new key load; sampled only in IDLE
- key_word  in  32  cipher-key word, MSB word first
- key_valid  in  1  key_word valid
- key_ready  out  1  controller accepts key_word this cycle
- ke_start  out  1  expander load strobe (one word per asserted cycle)
- ke_key  out  32  word to expander (= key_word)
- ke_done  in  1  expander reports round keys valid
- ke_round_n  out  4  round-key select to expander
- ke_r_index  out  2  32-bit slice select to expander
- ke_round_key  in  32  slice returned by expander
- rk_word  out  32  round-key word to datapath (= ke_round_key)
- rk_round  out  4  round number of rk_word
- rk_valid  out  1  rk_word valid
- rk_ready  in  1  datapath accepts rk_word
- rk_last  out  1  high with final word (round NR, word 3)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last word accepted
- err  out  1  sticky expansion-timeout flag

Behaviour:
- Reset (async, any state): state=IDLE; word_cnt=0; round_cnt=0; timer=0; err=0. All outputs 0, except ke_key and rk_word, which follow their inputs.
- States: IDLE, LOAD, EXPAND, ISSUE, DONE.
- IDLE:
  - start=1 -> LOAD, word_cnt=0.
  - key_valid is ignored; key_ready=0.
- LOAD:
  - key_ready=1.
  - ke_start = key_valid & key_ready (combinational); ke_key=key_word.
  - Each accepted word increments word_cnt.
  - Acceptance with word_cnt==3 -> EXPAND, word_cnt=0.
  - key_valid low stalls indefinitely; ke_start stays low.
- EXPAND:
  - Wait for ke_done=1 -> ISSUE, round_cnt=0, word_cnt=0.
  - ke_done already high on entry is taken on that first cycle.
- ISSUE:
  - rk_valid=1; ke_round_n=round_cnt; ke_r_index = 3 - word_cnt, so the MSB word goes first because the expander slice 0 is LSB.
  - rk_word=ke_round_key (combinational); rk_round=round_cnt.
  - rk_last = (round_cnt==NR && word_cnt==3).
  - On rk_valid & rk_ready: word_cnt++; on word_cnt wrap 3->0, round_cnt++.
  - Transfer with rk_last -> DONE.
  - rk_ready low: all outputs hold stable (AXI-style; valid never drops without transfer).
- DONE: done=1 for exactly one cycle -> IDLE.
- busy=1 in every state except IDLE.
- start while busy: ignored, no restart.
- Latency:
  - start to key_ready: 1 cycle.
  - Fourth key word to EXPAND: 1 cycle.
  - ke_done to first rk_valid: 1 cycle.
  - Minimum 44 cycles in ISSUE.
  - Last transfer to done: 1 cycle.
- Counters are 2-bit (word) and 4-bit (round); round_cnt never exceeds NR.

Optional Feature:
- Macro: AES_KEY_SCHED_TIMEOUT_EN.
- Defined:
  - A timer counts cycles in EXPAND; it is cleared on entry.
  - If timer reaches EXP_TIMEOUT without ke_done: err<=1 (sticky until reset) and state -> IDLE, with no rk_valid issued.
  - ke_done arriving in the same cycle as expiry wins: go to ISSUE, err unchanged.
- Undefined: no timer logic; EXPAND waits forever; err tied 0.

Test Plan:
- Reset: assert reset mid-ISSUE (round 5) -> all control outputs 0 and busy=0 immediately, without waiting for a clock edge; state IDLE after release.
- Key load: start, then key words 2b7e1516, 28aed2a6, abf71588, 09cf4f3c with key_valid gapped (1,0,1,1,0,1) -> ke_start pulses exactly 4 times with matching ke_key; EXPAND entered after the 4th.
- Full stream with FIPS-197 expander model and rk_ready=1:
  - 44 words in 44 consecutive cycles.
  - Round 0 words = the key words above; round 10 = d014f9a8, c9ee2589, e13f0cc8, b6630ca6.
  - rk_last only on b6630ca6; done pulses 1 cycle later.
- Backpressure: random rk_ready (~50%) -> rk_word/rk_round/ke_round_n/ke_r_index stable while rk_valid & !rk_ready; same 44-word sequence.
- Ignored inputs:
  - start pulsed in EXPAND and in ISSUE -> no restart, sequence unaffected.
  - key_valid in IDLE without start -> key_ready=0, no ke_start.
- Timeout (macro defined, EXP_TIMEOUT=64): ke_done held low -> err=1 at cycle 64 of EXPAND, return to IDLE, rk_valid never asserted. Macro undefined: still in EXPAND at cycle 1000, err=0.
